// File: rtl/f1_pkg.sv
// Shared definitions for the F1 start-light game: state encoding and ms count limits.
package f1_pkg;

  localparam int unsigned MS_W   = 14;
  localparam int unsigned MS_MAX = 9999;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE
  } state_t;

endpackage

// File: rtl/reaction_timer_edge_detect.sv
// Synchronous rising-edge detector; the history register resets to RST_VAL so a
// level already high at reset release is not seen as an edge.
module edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_d;

  // rise is registered, so a press reaches the FSM one cycle after the input rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_d <= RST_VAL;
      rise  <= 1'b0;
    end else begin
      din_d <= din;
      rise  <= din & ~din_d;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: measures ms from lights-out to the stop press, flags jump starts
// and timeouts, and keeps the best (lowest) valid time since reset or clear.
module reaction_timer
  import f1_pkg::*;
#(
  parameter int unsigned CNT_W  = MS_W,
  parameter int unsigned MAX_MS = MS_MAX
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             tick_ms,
  input  logic             arm,
  input  logic             lights_out,
  input  logic             stop,
  input  logic             clear_best,
  output logic [CNT_W-1:0] react_ms,
  output logic [CNT_W-1:0] best_ms,
  output logic             valid,
  output logic             jump_start,
  output logic             timeout,
  output logic             new_best,
  output logic             running
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MS);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] react_n, best_n, result;
  logic             valid_n, jump_n, timeout_n, new_best_n, latch;
  logic             press;

  edge_detect #(.RST_VAL(1'b1)) u_stop_edge (
    .clk   (sysclk),
    .rst_n (rst_n),
    .din   (stop),
    .rise  (press)
  );

  always_comb begin
    state_n    = state;
    count_n    = count;
    react_n    = react_ms;
    best_n     = best_ms;
    valid_n    = valid;
    jump_n     = jump_start;
    timeout_n  = timeout;
    new_best_n = 1'b0;
    latch      = 1'b0;
    result     = count;

    unique case (state)
      IDLE: ;
      ARMED: begin
        if (press) begin
          state_n = DONE;
          jump_n  = 1'b1;
          valid_n = 1'b0;
        end else if (lights_out) begin
          state_n = TIMING;
          count_n = '0;
        end
      end
      TIMING: begin
        if (press) begin
          state_n = DONE;
          react_n = count;
          valid_n = 1'b1;
          latch   = 1'b1;
        end else if (tick_ms) begin
          if (count >= MAX_C) begin
            state_n   = DONE;
            react_n   = MAX_C;
            timeout_n = 1'b1;
            valid_n   = 1'b1;
          end else begin
            count_n = count + 1'b1;
          end
        end
      end
      DONE: ;
      default: state_n = IDLE;
    endcase

    // arm overrides everything above, including any result latched this cycle.
    if (arm) begin
      state_n   = ARMED;
      count_n   = '0;
      valid_n   = 1'b0;
      jump_n    = 1'b0;
      timeout_n = 1'b0;
      react_n   = react_ms;
      latch     = 1'b0;
    end

    if (latch && (result < best_ms)) begin
      best_n     = result;
      new_best_n = 1'b1;
    end

    if (clear_best) begin
      best_n     = MAX_C;
      new_best_n = 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      react_ms   <= '0;
      best_ms    <= MAX_C;
      valid      <= 1'b0;
      jump_start <= 1'b0;
      timeout    <= 1'b0;
      new_best   <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      react_ms   <= react_n;
      best_ms    <= best_n;
      valid      <= valid_n;
      jump_start <= jump_n;
      timeout    <= timeout_n;
      new_best   <= new_best_n;
      running    <= (state_n == TIMING);
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: scenario tasks push expected results to a
// scoreboard queue when the decisive stimulus is driven and pop them on DUT output.
module tb_reaction_timer;

  localparam int W    = 14;
  localparam int MAXV = 9999;

  logic         sysclk = 1'b0;
  logic         rst_n = 1'b0, tick_ms = 1'b0, arm = 1'b0, lights_out = 1'b0;
  logic         stop = 1'b0, clear_best = 1'b0;
  logic [W-1:0] react_ms, best_ms;
  logic         valid, jump_start, timeout, new_best, running;

  typedef struct {
    int react;
    int best;
    bit vld;
    bit jmp;
    bit tmo;
    int nb;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0, checks = 0, nb_count = 0, model_best = MAXV, nb0;
  bit   ok;

  reaction_timer #(.CNT_W(W), .MAX_MS(MAXV)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .tick_ms    (tick_ms),
    .arm        (arm),
    .lights_out (lights_out),
    .stop       (stop),
    .clear_best (clear_best),
    .react_ms   (react_ms),
    .best_ms    (best_ms),
    .valid      (valid),
    .jump_start (jump_start),
    .timeout    (timeout),
    .new_best   (new_best),
    .running    (running)
  );

  always #10 sysclk = ~sysclk;

  always @(negedge sysclk) if (new_best === 1'b1) nb_count++;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_lights();
    lights_out = 1'b1; step(); lights_out = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1; step();
    end
    tick_ms = 1'b0;
  endtask

  task automatic start_run(input int n);
    pulse_arm(); pulse_lights(); do_ticks(n);
  endtask

  // Raises stop and waits (bounded) for a result or jump flag.
  task automatic press_wait(output bit found);
    found = 1'b0;
    stop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid === 1'b1 || jump_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    step(); step();
    stop = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    checks++; if (react_ms !== 0) begin errors++; $display("FAIL reset react_ms: got %0d want 0", react_ms); end
    checks++; if (best_ms !== MAXV) begin errors++; $display("FAIL reset best_ms: got %0d want %0d", best_ms, MAXV); end
    checks++; if ({valid, jump_start, timeout, new_best, running} !== 5'b0) begin
      errors++; $display("FAIL reset flags: got %b want 00000", {valid, jump_start, timeout, new_best, running});
    end
  endtask

  task automatic test_basic();
    pulse_arm();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL armed running: got %b want 0", running); end
    pulse_lights();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL timing running: got %b want 1", running); end
    do_ticks(237);
    nb0 = nb_count;
    sb.push_back('{react: 237, best: 237, vld: 1, jmp: 0, tmo: 0, nb: 1});
    model_best = 237;
    stop = 1'b1; step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL latency early valid: got %b want 0", valid); end
    step();
    e = sb.pop_front();
    checks++; if (valid !== e.vld) begin errors++; $display("FAIL basic valid: got %b want %b", valid, e.vld); end
    checks++; if (react_ms !== e.react) begin errors++; $display("FAIL basic react_ms: got %0d want %0d", react_ms, e.react); end
    checks++; if (best_ms !== e.best) begin errors++; $display("FAIL basic best_ms: got %0d want %0d", best_ms, e.best); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL basic running: got %b want 0", running); end
    step(); step(); step();
    stop = 1'b0; step();
    checks++; if (nb_count - nb0 !== e.nb) begin errors++; $display("FAIL basic new_best pulses: got %0d want %0d", nb_count - nb0, e.nb); end
  endtask

  task automatic test_jump_start();
    pulse_arm();
    sb.push_back('{react: 237, best: model_best, vld: 0, jmp: 1, tmo: 0, nb: 0});
    nb0 = nb_count;
    press_wait(ok);
    checks++; if (!ok) begin errors++; $display("FAIL jump wait: got timeout want jump_start"); end
    e = sb.pop_front();
    checks++; if (jump_start !== e.jmp || valid !== e.vld) begin
      errors++; $display("FAIL jump flags: got jmp=%b vld=%b want jmp=%b vld=%b", jump_start, valid, e.jmp, e.vld);
    end
    checks++; if (react_ms !== e.react || best_ms !== e.best) begin
      errors++; $display("FAIL jump values: got react=%0d best=%0d want react=%0d best=%0d", react_ms, best_ms, e.react, e.best);
    end
    pulse_lights(); step();
    checks++; if (running !== 1'b0 || jump_start !== 1'b1) begin
      errors++; $display("FAIL jump lights_out ignored: got run=%b jmp=%b want run=0 jmp=1", running, jump_start);
    end
    checks++; if (nb_count - nb0 !== e.nb) begin errors++; $display("FAIL jump new_best: got %0d want %0d", nb_count - nb0, e.nb); end
  endtask

  task automatic test_timeout();
    pulse_arm(); pulse_lights();
    sb.push_back('{react: MAXV, best: model_best, vld: 1, jmp: 0, tmo: 1, nb: 0});
    nb0 = nb_count;
    do_ticks(9999);
    checks++; if (running !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL tick 9999: got run=%b vld=%b want run=1 vld=0", running, valid);
    end
    do_ticks(1);
    e = sb.pop_front();
    checks++; if (react_ms !== e.react || timeout !== e.tmo || valid !== e.vld) begin
      errors++; $display("FAIL timeout result: got react=%0d tmo=%b vld=%b want react=%0d tmo=%b vld=%b",
                         react_ms, timeout, valid, e.react, e.tmo, e.vld);
    end
    checks++; if (best_ms !== e.best || running !== 1'b0) begin
      errors++; $display("FAIL timeout best/run: got best=%0d run=%b want best=%0d run=0", best_ms, running, e.best);
    end
    do_ticks(20); step();
    checks++; if (react_ms !== MAXV || valid !== 1'b1 || nb_count - nb0 !== e.nb) begin
      errors++; $display("FAIL timeout held: got react=%0d vld=%b nb=%0d want react=%0d vld=1 nb=%0d",
                         react_ms, valid, nb_count - nb0, MAXV, e.nb);
    end
  endtask

  task automatic test_best_sequence();
    int rs[3] = '{300, 250, 250};
    clear_best = 1'b1; step(); clear_best = 1'b0;
    model_best = MAXV;
    checks++; if (best_ms !== MAXV) begin errors++; $display("FAIL clear before seq: got %0d want %0d", best_ms, MAXV); end
    for (int k = 0; k < 3; k++) begin
      e = '{react: rs[k], best: 0, vld: 1, jmp: 0, tmo: 0, nb: (rs[k] < model_best) ? 1 : 0};
      if (rs[k] < model_best) model_best = rs[k];
      e.best = model_best;
      sb.push_back(e);
      start_run(rs[k]);
      nb0 = nb_count;
      press_wait(ok);
      e = sb.pop_front();
      checks++; if (!ok || react_ms !== e.react || valid !== e.vld) begin
        errors++; $display("FAIL seq%0d result: got ok=%b react=%0d vld=%b want react=%0d vld=1", k, ok, react_ms, valid, e.react);
      end
      checks++; if (best_ms !== e.best || nb_count - nb0 !== e.nb) begin
        errors++; $display("FAIL seq%0d best: got best=%0d nb=%0d want best=%0d nb=%0d", k, best_ms, nb_count - nb0, e.best, e.nb);
      end
    end
    clear_best = 1'b1; step(); clear_best = 1'b0;
    model_best = MAXV;
    checks++; if (best_ms !== MAXV) begin errors++; $display("FAIL clear_best: got %0d want %0d", best_ms, MAXV); end
  endtask

  task automatic test_stop_held();
    stop = 1'b1;
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; step();
    model_best = MAXV;
    pulse_arm(); step();
    checks++; if (jump_start !== 1'b0) begin errors++; $display("FAIL held stop jump: got %b want 0", jump_start); end
    pulse_lights(); do_ticks(5);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL held stop running: got %b want 1", running); end
    stop = 1'b0; step();
    sb.push_back('{react: 5, best: 5, vld: 1, jmp: 0, tmo: 0, nb: 1});
    model_best = 5;
    nb0 = nb_count;
    press_wait(ok);
    e = sb.pop_front();
    checks++; if (!ok || react_ms !== e.react || best_ms !== e.best || nb_count - nb0 !== e.nb) begin
      errors++; $display("FAIL held stop result: got ok=%b react=%0d best=%0d nb=%0d want react=%0d best=%0d nb=%0d",
                         ok, react_ms, best_ms, nb_count - nb0, e.react, e.best, e.nb);
    end
  endtask

  task automatic test_rearm();
    start_run(40);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL rearm pre running: got %b want 1", running); end
    pulse_arm();
    checks++; if (running !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL rearm state: got run=%b vld=%b want run=0 vld=0", running, valid);
    end
    lights_out = 1'b1; tick_ms = 1'b1; step(); lights_out = 1'b0; tick_ms = 1'b0;
    do_ticks(12);
    sb.push_back('{react: 12, best: model_best, vld: 1, jmp: 0, tmo: 0, nb: 0});
    press_wait(ok);
    e = sb.pop_front();
    checks++; if (!ok || react_ms !== e.react || best_ms !== e.best) begin
      errors++; $display("FAIL rearm result: got ok=%b react=%0d best=%0d want react=%0d best=%0d", ok, react_ms, best_ms, e.react, e.best);
    end
  endtask

  task automatic test_clear_collision();
    start_run(3);
    sb.push_back('{react: 3, best: MAXV, vld: 1, jmp: 0, tmo: 0, nb: 0});
    model_best = MAXV;
    nb0 = nb_count;
    stop = 1'b1; step();
    clear_best = 1'b1; step(); clear_best = 1'b0;
    e = sb.pop_front();
    checks++; if (react_ms !== e.react || valid !== e.vld || best_ms !== e.best) begin
      errors++; $display("FAIL clear collision: got react=%0d vld=%b best=%0d want react=%0d vld=1 best=%0d",
                         react_ms, valid, best_ms, e.react, e.best);
    end
    step(); step();
    stop = 1'b0; step();
    checks++; if (nb_count - nb0 !== e.nb) begin errors++; $display("FAIL clear collision new_best: got %0d want 0", nb_count - nb0); end
  endtask

  task automatic test_press_at_max();
    start_run(MAXV);
    sb.push_back('{react: MAXV, best: model_best, vld: 1, jmp: 0, tmo: 0, nb: 0});
    nb0 = nb_count;
    press_wait(ok);
    e = sb.pop_front();
    checks++; if (!ok || react_ms !== e.react || timeout !== e.tmo || valid !== e.vld) begin
      errors++; $display("FAIL press at max: got ok=%b react=%0d tmo=%b vld=%b want react=%0d tmo=0 vld=1",
                         ok, react_ms, timeout, valid, e.react);
    end
    checks++; if (best_ms !== e.best || nb_count - nb0 !== e.nb) begin
      errors++; $display("FAIL press at max best: got best=%0d nb=%0d want best=%0d nb=0", best_ms, nb_count - nb0, e.best);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jump_start();
    test_timeout();
    test_best_sequence();
    test_stop_held();
    test_rearm();
    test_clear_collision();
    test_press_at_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
